// File: rtl/freq_lock_pkg.sv
// Shared types and helpers for the frequency lock controller.
package freq_lock_pkg;

    localparam int unsigned PERIOD_W = 8;
    localparam int unsigned WDOG_W   = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRamp   = 3'd1,
        StTrack  = 3'd2,
        StLocked = 3'd3,
        StFault  = 3'd4
    } state_e;

    // Bits needed to hold values 0 .. value-1 (never less than one bit).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // Fold a 9-bit intermediate period back into the legal range [1,255].
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W:0] value);
        if (value == '0) begin
            return PERIOD_W'(1);
        end else if (value[PERIOD_W]) begin
            return '1;
        end
        return value[PERIOD_W-1:0];
    endfunction

endpackage

// File: rtl/freq_lock_wdog.sv
// psi watchdog: counts clk cycles while enabled, restarts on a kick (psi fall) or clear
// (state change), and flags expiry in the terminal cycle unless that cycle is kicked.
module freq_lock_wdog
    import freq_lock_pkg::*;
#(
    parameter logic [WDOG_W-1:0] TIMEOUT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic kick,
    output logic expire
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    // Next count: restart on any clear source, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear || kick) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A fall in the terminal cycle rescues the loop.
    always_comb begin
        expire = enable && !kick && (cnt_q == (TIMEOUT - WDOG_W'(1)));
    end

endmodule

// File: rtl/freq_lock_ctrl.sv
// Regulator lock sequencer: holds the regulator in reset while idle, ramps set_period to the
// sampled target, tracks inc/dec activity to declare and supervise lock, and runs a psi watchdog.
// Optional feature: define FREQ_LOCK_RELOCK_EN to fall back to TRACK on loss of lock instead of
// going to FAULT.
module freq_lock_ctrl
    import freq_lock_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] START_PERIOD = 8'd16,
    parameter logic [PERIOD_W-1:0] STEP         = 8'd1,
    parameter int unsigned         LOCK_CNT     = 4,
    parameter int unsigned         LOSS_CNT     = 3,
    parameter int unsigned         MAX_ADJ      = 255,
    parameter logic [WDOG_W-1:0]   TIMEOUT      = 16'd50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] target_period,
    input  logic                psi,
    input  logic                inc,
    input  logic                dec,
    output logic [PERIOD_W-1:0] set_period,
    output logic                reg_rst,
    output logic                busy,
    output logic                locked,
    output logic                fault,
    output logic [2:0]          state_o
);

    localparam int unsigned OkW   = clog2(LOCK_CNT + 1);
    localparam int unsigned AdjW  = clog2(MAX_ADJ + 1);
    localparam int unsigned MissW = clog2(LOSS_CNT + 1);

    state_e state_q, state_d;

    logic                psi_q;
    logic                fall;
    logic                adj_evt;
    logic                clean_evt;
    logic                wdog_en;
    logic                wdog_clear;
    logic                wdog_expire;

    logic [PERIOD_W-1:0] sp_q, sp_d;
    logic [PERIOD_W-1:0] tgt_q, tgt_d;
    logic [PERIOD_W-1:0] ramp_next;
    logic [OkW-1:0]      ok_q, ok_d, ok_step;
    logic [AdjW-1:0]     adj_q, adj_d, adj_step;
    logic [MissW-1:0]    miss_q, miss_d, miss_step;
    logic                ok_hit;
    logic                adj_hit;
    logic                miss_hit;

    // psi edge detection and qualified regulator strobes.
    always_comb begin
        fall      = psi_q && !psi;
        adj_evt   = fall && (inc || dec);
        clean_evt = fall && !(inc || dec);
    end

    // Saturating counter updates for the current fall, and the thresholds they hit.
    always_comb begin
        ok_step   = ok_q;
        adj_step  = adj_q;
        miss_step = miss_q;
        if (adj_evt) begin
            ok_step = '0;
            if (adj_q != AdjW'(MAX_ADJ)) begin
                adj_step = adj_q + AdjW'(1);
            end
            if (miss_q != MissW'(LOSS_CNT)) begin
                miss_step = miss_q + MissW'(1);
            end
        end else if (clean_evt) begin
            miss_step = '0;
            if (ok_q != OkW'(LOCK_CNT)) begin
                ok_step = ok_q + OkW'(1);
            end
        end
        ok_hit   = clean_evt && (ok_step == OkW'(LOCK_CNT));
        adj_hit  = adj_evt && (adj_step == AdjW'(MAX_ADJ));
        miss_hit = adj_evt && (miss_step == MissW'(LOSS_CNT));
    end

    // One ramp step toward the target, never overshooting it.
    always_comb begin
        logic [PERIOD_W:0] sp9, tgt9, step9;
        sp9   = {1'b0, sp_q};
        tgt9  = {1'b0, tgt_q};
        step9 = {1'b0, STEP};
        if (tgt_q > sp_q) begin
            ramp_next = ((sp9 + step9) > tgt9) ? tgt_q : clamp_period(sp9 + step9);
        end else begin
            ramp_next = (sp9 < (tgt9 + step9)) ? tgt_q : clamp_period(sp9 - step9);
        end
    end

    // Watchdog runs only while the regulator is active; a state change restarts it.
    always_comb begin
        wdog_en    = (state_q == StRamp) || (state_q == StTrack) || (state_q == StLocked);
        wdog_clear = (state_d != state_q);
    end

    freq_lock_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .enable (wdog_en),
        .clear  (wdog_clear),
        .kick   (fall),
        .expire (wdog_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything except rst.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = (target_period == '0) ? StFault : StRamp;
                    end
                end
                StRamp: begin
                    if (wdog_expire) begin
                        state_d = StFault;
                    end else if (sp_q == tgt_q) begin
                        state_d = StTrack;
                    end
                end
                StTrack: begin
                    if (wdog_expire) begin
                        state_d = StFault;
                    end else if (ok_hit) begin
                        state_d = StLocked;
                    end else if (adj_hit) begin
                        state_d = StFault;
                    end
                end
                StLocked: begin
                    if (wdog_expire) begin
                        state_d = StFault;
                    end else if (miss_hit) begin
`ifdef FREQ_LOCK_RELOCK_EN
                        state_d = StTrack;
`else
                        state_d = StFault;
`endif
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Datapath next values: set_period, sampled target and the lock counters.
    always_comb begin
        sp_d   = sp_q;
        tgt_d  = tgt_q;
        ok_d   = ok_q;
        adj_d  = adj_q;
        miss_d = miss_q;
        if (abort) begin
            sp_d   = START_PERIOD;
            ok_d   = '0;
            adj_d  = '0;
            miss_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        tgt_d  = target_period;
                        sp_d   = START_PERIOD;
                        ok_d   = '0;
                        adj_d  = '0;
                        miss_d = '0;
                    end
                end
                StRamp: begin
                    if (sp_q == tgt_q) begin
                        ok_d  = '0;
                        adj_d = '0;
                    end else if (fall) begin
                        sp_d = ramp_next;
                    end
                end
                StTrack: begin
                    ok_d  = ok_step;
                    adj_d = adj_step;
                    if (state_d == StLocked) begin
                        miss_d = '0;
                    end
                end
                StLocked: begin
                    miss_d = miss_step;
                    if (state_d == StTrack) begin
                        ok_d  = '0;
                        adj_d = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            psi_q  <= 1'b0;
            sp_q   <= START_PERIOD;
            tgt_q  <= '0;
            ok_q   <= '0;
            adj_q  <= '0;
            miss_q <= '0;
        end else begin
            psi_q  <= psi;
            sp_q   <= sp_d;
            tgt_q  <= tgt_d;
            ok_q   <= ok_d;
            adj_q  <= adj_d;
            miss_q <= miss_d;
        end
    end

    // Outputs decoded from the state register.
    always_comb begin
        set_period = sp_q;
        reg_rst    = (state_q == StIdle) || (state_q == StFault);
        busy       = (state_q == StRamp) || (state_q == StTrack) || (state_q == StLocked);
        locked     = (state_q == StLocked);
        fault      = (state_q == StFault);
        state_o    = state_q;
    end

endmodule

// File: tb/tb_freq_lock_ctrl.sv
// Directed bench for freq_lock_ctrl with a scoreboard of expected outputs.
module tb_freq_lock_ctrl;
    import freq_lock_pkg::*;

    localparam logic [15:0] TO = 16'd500;

    logic       clk = 1'b0;
    logic       rst, start, abort, psi, inc, dec;
    logic [7:0] target_period;
    logic [7:0] set_period;
    logic       reg_rst, busy, locked, fault;
    logic [2:0] state_o;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;

    item_t       sb[$];
    int unsigned checks = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    freq_lock_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .target_period (target_period),
        .psi           (psi),
        .inc           (inc),
        .dec           (dec),
        .set_period    (set_period),
        .reg_rst       (reg_rst),
        .busy          (busy),
        .locked        (locked),
        .fault         (fault),
        .state_o       (state_o)
    );

    task automatic push(input string tag, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        item_t it;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%0d required=an entry", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) begin
                passed++;
            end else begin
                $error("FAIL %s observed=%0d required=%0d", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        push(tag, exp);
        pop_cmp(obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One psi period ending in a fall, with the given strobes on the fall cycle.
    task automatic do_fall(input logic i, input logic d);
        psi = 1'b1;
        tick();
        psi = 1'b0;
        inc = i;
        dec = d;
        tick();
        inc = 1'b0;
        dec = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] tgt);
        target_period = tgt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] exp_sp;
        int unsigned lock_seen;

        rst = 1'b1; start = 1'b0; abort = 1'b0; psi = 1'b0; inc = 1'b0; dec = 1'b0;
        target_period = 8'd0;
        tick();
        tick();
        chk("rst_state", 32'(StIdle), 32'(state_o));
        chk("rst_set_period", 32'd16, 32'(set_period));
        chk("rst_reg_rst", 32'd1, 32'(reg_rst));
        chk("rst_busy", 32'd0, 32'(busy));
        chk("rst_locked", 32'd0, 32'(locked));
        chk("rst_fault", 32'd0, 32'(fault));
        rst = 1'b0;
        tick();

        // Ramp from 16 to 20; a later target change must not matter.
        push("ramp_entry_state", 32'(StRamp));
        do_start(8'd20);
        target_period = 8'd99;
        pop_cmp(32'(state_o));
        chk("ramp_sp0", 32'd16, 32'(set_period));
        chk("ramp_reg_rst", 32'd0, 32'(reg_rst));
        exp_sp = 8'd16;
        for (int k = 0; k < 4; k++) begin
            exp_sp = (exp_sp + 8'd1 > 8'd20) ? 8'd20 : exp_sp + 8'd1;
            push("ramp_sp_step", 32'(exp_sp));
            do_fall(1'b0, 1'b0);
            pop_cmp(32'(set_period));
        end
        tick();
        chk("track_entry", 32'(StTrack), 32'(state_o));
        chk("track_reg_rst", 32'd0, 32'(reg_rst));

        // Four clean falls declare lock.
        for (int k = 0; k < 4; k++) begin
            do_fall(1'b0, 1'b0);
            if (k == 2) chk("no_lock_after_3", 32'd0, 32'(locked));
        end
        chk("locked_after_4", 32'd1, 32'(locked));
        chk("locked_busy", 32'd1, 32'(busy));

        // Two misses then a clean period keep lock; three misses lose it.
        do_fall(1'b0, 1'b1);
        do_fall(1'b0, 1'b1);
        do_fall(1'b0, 1'b0);
        tick();
        chk("lock_held", 32'(StLocked), 32'(state_o));
        do_fall(1'b0, 1'b1);
        do_fall(1'b0, 1'b1);
        chk("lock_held_2miss", 32'(StLocked), 32'(state_o));
        do_fall(1'b0, 1'b1);
`ifdef FREQ_LOCK_RELOCK_EN
        chk("lock_loss", 32'(StTrack), 32'(state_o));
`else
        chk("lock_loss", 32'(StFault), 32'(state_o));
`endif
        do_abort();
        chk("abort_idle", 32'(StIdle), 32'(state_o));
        chk("abort_sp", 32'd16, 32'(set_period));

        // START == target: one RAMP cycle, then adjusted falls run out MAX_ADJ.
        do_start(8'd16);
        chk("ramp_one_cycle", 32'(StRamp), 32'(state_o));
        tick();
        chk("track_direct", 32'(StTrack), 32'(state_o));
        lock_seen = 0;
        for (int i = 0; i < 255; i++) begin
            if (i == 254) chk("track_before_max", 32'(StTrack), 32'(state_o));
            do_fall(1'b1, 1'b0);
            if (i < 254) begin
                do_fall(1'b0, 1'b0);
                if (locked) lock_seen++;
            end
        end
        chk("alt_never_locked", 32'd0, 32'(lock_seen));
        chk("max_adj_fault", 32'd1, 32'(fault));
        chk("max_adj_reg_rst", 32'd1, 32'(reg_rst));
        chk("max_adj_busy", 32'd0, 32'(busy));
        do_start(8'd20);
        chk("start_in_fault", 32'(StFault), 32'(state_o));
        chk("fault_sp_held", 32'd16, 32'(set_period));
        do_abort();
        chk("fault_abort", 32'(StIdle), 32'(state_o));

        // Watchdog: psi stuck low expires in the terminal cycle.
        do_start(8'd20);
        repeat (int'(TO) - 1) tick();
        chk("wdog_terminal", 32'(StRamp), 32'(state_o));
        tick();
        chk("wdog_fault", 32'd1, 32'(fault));
        do_abort();

        // A fall in the terminal cycle rescues and restarts the count.
        do_start(8'd20);
        repeat (int'(TO) - 2) tick();
        psi = 1'b1;
        tick();
        psi = 1'b0;
        tick();
        chk("wdog_rescued", 32'(StRamp), 32'(state_o));
        chk("wdog_rescue_sp", 32'd17, 32'(set_period));
        repeat (int'(TO) - 1) tick();
        chk("wdog_restart_term", 32'(StRamp), 32'(state_o));
        tick();
        chk("wdog_restart_fault", 32'(StFault), 32'(state_o));
        do_abort();

        // Abort mid-ramp, zero target, reset mid-lock.
        do_start(8'd30);
        do_fall(1'b0, 1'b0);
        do_fall(1'b0, 1'b0);
        chk("mid_ramp_sp", 32'd18, 32'(set_period));
        do_abort();
        chk("mid_abort_state", 32'(StIdle), 32'(state_o));
        chk("mid_abort_sp", 32'd16, 32'(set_period));
        chk("mid_abort_reg_rst", 32'd1, 32'(reg_rst));
        do_start(8'd0);
        chk("zero_target", 32'(StFault), 32'(state_o));
        chk("zero_target_fault", 32'd1, 32'(fault));
        do_abort();
        do_start(8'd16);
        tick();
        for (int k = 0; k < 4; k++) do_fall(1'b0, 1'b0);
        chk("relock_again", 32'd1, 32'(locked));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_state", 32'(StIdle), 32'(state_o));
        chk("rst2_sp", 32'd16, 32'(set_period));
        chk("rst2_reg_rst", 32'd1, 32'(reg_rst));
        chk("rst2_flags", 32'd0, 32'({busy, locked, fault}));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
